// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch: pc_next, credit-limited imem reads, in-order tagged queue to decode
// Optional FETCH_PERF_EN adds a saturating stall_cnt output.
module fetch_unit #(
  parameter int AW     = 19,
  parameter int IW     = 19,
  parameter int QDEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] pc,
  output logic [AW-1:0] pc_next,
  output logic          imem_req_valid,
  output logic [AW-1:0] imem_req_addr,
  input  logic          imem_req_ready,
  input  logic          imem_rsp_valid,
  input  logic [IW-1:0] imem_rsp_data,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  output logic          inst_valid,
  output logic [IW-1:0] inst_data,
  output logic [AW-1:0] inst_pc,
  input  logic          inst_ready
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]   stall_cnt
`endif
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] q_rd_q, q_rd_d, q_wr_q, q_wr_d;
  logic [PW-1:0] a_rd_q, a_rd_d, a_wr_q, a_wr_d;
  logic [CW-1:0] q_cnt_q, q_cnt_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_q, drop_d;

  logic [IW-1:0] q_data_q [QDEPTH];
  logic [AW-1:0] q_pc_q   [QDEPTH];
  logic [AW-1:0] a_addr_q [QDEPTH];

  logic [CW:0] credit;
  logic        req_fire, pop, rsp_ok, rsp_keep;

  // Queue entries plus in-flight requests never exceed QDEPTH, so pushes cannot overflow.
  assign credit         = {1'b0, q_cnt_q} + {1'b0, outstanding_q};
  assign imem_req_valid = rst & ~redirect_valid & (credit < (CW+1)'(QDEPTH));
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid & imem_req_ready;
  assign inst_valid     = (q_cnt_q != '0);
  assign inst_data      = q_data_q[q_rd_q];
  assign inst_pc        = q_pc_q[q_rd_q];
  assign pop            = inst_valid & inst_ready;
  assign rsp_ok         = imem_rsp_valid & (outstanding_q != '0);
  assign rsp_keep       = rsp_ok & ~redirect_valid & (drop_q == '0);

  always_comb begin
    pc_next = pc;
    if (redirect_valid)
      pc_next = redirect_pc;
    else if (req_fire)
      pc_next = AW'(pc + AW'(1));
  end

  always_comb begin
    q_rd_d        = q_rd_q;
    q_wr_d        = q_wr_q;
    a_rd_d        = a_rd_q;
    a_wr_d        = a_wr_q;
    q_cnt_d       = q_cnt_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    if (redirect_valid) begin
      // Everything still in flight belongs to the squashed path and must be dropped on return.
      q_rd_d        = '0;
      q_wr_d        = '0;
      a_rd_d        = '0;
      a_wr_d        = '0;
      q_cnt_d       = '0;
      outstanding_d = outstanding_q - CW'(rsp_ok);
      drop_d        = outstanding_q - CW'(rsp_ok);
    end else begin
      if (req_fire) a_wr_d = a_wr_q + PW'(1);
      if (rsp_keep) begin
        a_rd_d = a_rd_q + PW'(1);
        q_wr_d = q_wr_q + PW'(1);
      end
      if (pop) q_rd_d = q_rd_q + PW'(1);
      q_cnt_d       = q_cnt_q + CW'(rsp_keep) - CW'(pop);
      outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_ok);
      if (rsp_ok && drop_q != '0) drop_d = drop_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_rd_q        <= '0;
      q_wr_q        <= '0;
      a_rd_q        <= '0;
      a_wr_q        <= '0;
      q_cnt_q       <= '0;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      q_rd_q        <= q_rd_d;
      q_wr_q        <= q_wr_d;
      a_rd_q        <= a_rd_d;
      a_wr_q        <= a_wr_d;
      q_cnt_q       <= q_cnt_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  // Payload storage needs no reset; validity is carried by the pointers and counts.
  always_ff @(posedge clk) begin
    if (req_fire) a_addr_q[a_wr_q] <= pc;
    if (rsp_keep) begin
      q_data_q[q_wr_q] <= imem_rsp_data;
      q_pc_q[q_wr_q]   <= a_addr_q[a_rd_q];
    end
  end

`ifdef FETCH_PERF_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!inst_valid && !redirect_valid && stall_cnt_q != 16'hFFFF)
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_cnt_q <= '0;
    else      stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized + directed bench for fetch_unit against an epoch-based stream model
module tb_fetch_unit;

  localparam int AW = 19;
  localparam int IW = 19;
  localparam int QDEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] pc;
  logic [AW-1:0] pc_next;
  logic          imem_req_valid;
  logic [AW-1:0] imem_req_addr;
  logic          imem_req_ready;
  logic          imem_rsp_valid;
  logic [IW-1:0] imem_rsp_data;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          inst_valid;
  logic [IW-1:0] inst_data;
  logic [AW-1:0] inst_pc;
  logic          inst_ready;
`ifdef FETCH_PERF_EN
  logic [15:0]   stall_cnt;
`endif

  fetch_unit #(.AW(AW), .IW(IW), .QDEPTH(QDEPTH)) dut (
    .clk(clk), .rst(rst), .pc(pc), .pc_next(pc_next),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .inst_valid(inst_valid), .inst_data(inst_data),
    .inst_pc(inst_pc), .inst_ready(inst_ready)
`ifdef FETCH_PERF_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    int            epoch;
    int            due;
  } ent_t;

  ent_t          inflight[$];
  logic [AW-1:0] refq[$];
  logic [AW-1:0] pop_log[$];
  logic [AW-1:0] pc_model;
  int            epoch, cyc, last_due, lat, obs_fire_cnt;
  int            n_checks, n_errors;
  logic [15:0]   exp_stall;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [IW-1:0] memword(input logic [AW-1:0] a);
    return {a[6:0], a[18:7]} ^ 19'h2A5A5;
  endfunction

  function automatic logic [31:0] log_at(input int i);
    return (i < pop_log.size()) ? {13'b0, pop_log[i]} : 32'hDEADBEEF;
  endfunction

  always @(posedge clk)
    if (rst) assert (!(imem_rsp_valid && dut.outstanding_q == '0))
      else $error("FAIL rsp_without_outstanding at cycle %0d", cyc);

  // One clock: drive inputs, compare combinational outputs to the model, advance the model.
  task automatic step(input bit redir, input logic [AW-1:0] rpc, input bit mready, input bit iready);
    bit rsp, exp_rv, fire, pop, stall_inc;
    logic [AW-1:0] exp_next;
    ent_t h;
    int due;
    rsp = inflight.size() > 0 && inflight[0].due <= cyc;
    redirect_valid = redir;
    redirect_pc    = rpc;
    imem_req_ready = mready;
    inst_ready     = iready;
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? memword(inflight[0].addr) : IW'($urandom);
    pc             = pc_model;
    #1;
    exp_rv = !redir && (refq.size() + inflight.size() < QDEPTH);
    fire   = exp_rv && mready;
    exp_next = redir ? rpc : (fire ? AW'(pc_model + 1) : pc_model);
    check("req_valid", imem_req_valid, exp_rv);
    check("req_addr", imem_req_addr, pc_model);
    check("pc_next", pc_next, exp_next);
    check("inst_valid", inst_valid, refq.size() != 0);
    if (refq.size() != 0) begin
      check("inst_pc", inst_pc, refq[0]);
      check("inst_data", inst_data, memword(refq[0]));
    end
    if (imem_req_valid && mready) obs_fire_cnt++;
    pop = refq.size() != 0 && iready;
    if (inst_valid && iready) pop_log.push_back(inst_pc);
    stall_inc = refq.size() == 0 && !redir;
`ifdef FETCH_PERF_EN
    check("stall_cnt", stall_cnt, exp_stall);
`endif
    @(posedge clk);
    #1;
    if (pop) void'(refq.pop_front());
    if (rsp) begin
      h = inflight.pop_front();
      if (!redir && h.epoch == epoch) refq.push_back(h.addr);
    end
    if (redir) begin
      refq.delete();
      epoch++;
    end
    if (fire) begin
      due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
      inflight.push_back('{pc_model, epoch, due});
      last_due = due;
    end
    if (stall_inc && exp_stall != 16'hFFFF) exp_stall++;
    pc_model = exp_next;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_req_ready = 1'b1;
    inst_ready = 1'b1;
    #1;
    check("rst_req_valid", imem_req_valid, 1'b0);
    check("rst_inst_valid", inst_valid, 1'b0);
    inflight.delete();
    refq.delete();
    pop_log.delete();
    pc_model = '0;
    pc = '0;
    last_due = cyc;
    exp_stall = '0;
    obs_fire_cnt = 0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
  endtask

  initial begin
    n_checks = 0; n_errors = 0; cyc = 0; epoch = 0; lat = 1;
    redirect_pc = '0; imem_rsp_data = '0;

    // Streaming from pc=0 with single-cycle memory and decode always ready.
    do_reset();
    repeat (10) step(0, '0, 1, 1);
    for (int i = 0; i < 3; i++) check("t1_pc_seq", log_at(i), i);

    // Decode stalls: only QDEPTH requests may issue, then resume in order.
    do_reset();
    repeat (10) step(0, '0, 1, 0);
    check("t2_fires", obs_fire_cnt, QDEPTH);
    repeat (8) step(0, '0, 1, 1);
    for (int i = 0; i < 6; i++) check("t2_order", log_at(i), i);

    // Wrap of the PC across the top of the address space.
    step(1, 19'h7FFFE, 1, 1);
    pop_log.delete();
    repeat (10) step(0, '0, 1, 1);
    check("t3_wrap0", log_at(0), 32'h7FFFE);
    check("t3_wrap1", log_at(1), 32'h7FFFF);
    check("t3_wrap2", log_at(2), 32'h00000);

    // Redirect with three requests outstanding and 4-cycle memory latency.
    do_reset();
    lat = 4;
    repeat (3) step(0, '0, 1, 1);
    check("t4_outstanding", dut.outstanding_q, 3);
    step(1, 19'h00100, 1, 1);
    pop_log.delete();
    repeat (15) step(0, '0, 1, 1);
    check("t4_first_pc", log_at(0), 32'h00100);

    // Redirect coinciding with a response and a pop.
    do_reset();
    lat = 1;
    repeat (6) step(0, '0, 1, 1);
    pop_log.delete();
    step(1, 19'h00200, 1, 1);
    check("t5_pop_done", pop_log.size(), 1);
    pop_log.delete();
    repeat (10) step(0, '0, 1, 1);
    check("t5_first_pc", log_at(0), 32'h00200);

`ifdef FETCH_PERF_EN
    do_reset();
    repeat (20) step(0, '0, 0, 1);
    check("t6_stall20", stall_cnt, 20);
    force dut.stall_cnt_q = 16'hFFFF;
    #1;
    release dut.stall_cnt_q;
    exp_stall = 16'hFFFF;
    repeat (4) step(0, '0, 0, 1);
    check("t6_saturate", stall_cnt, 16'hFFFF);
`endif

    // Randomized traffic with occasional redirects, latency changes and one mid-run reset.
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 49) == 0) lat = $urandom_range(1, 4);
      if (n == 700) do_reset();
      step($urandom_range(0, 19) == 0, AW'($urandom), $urandom_range(0, 3) != 0,
           $urandom_range(0, 3) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
